fifo_uart_tx: RTL and testbench

- Serial transmitter downstream of the 16x8 FIFO.
- Pops one byte at a time from the FIFO read port using fifo_rd_en, fifo_rd_data and fifo_empty.
- Shifts each byte out LSB-first as an asynchronous serial frame: start, 8 data bits, optional parity, stop.
- Feeds the board-level TX pin; drains the FIFO autonomously while enabled.

---
 rtl/fifo_uart_tx.sv | 218 +++++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Serial transmitter that drains a 16x8 FIFO with a registered read port.
// Each byte is popped with a single-cycle fifo_rd_en pulse, captured one cycle
// later, and shifted out LSB-first as start bit, 8 data bits, an optional
// parity bit and STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clocks.
//
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even-parity bit
// (XOR of the 8 data bits) between the last data bit and the stop period.
// With the macro undefined there is no PARITY state and no parity logic.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   enable        permits starting new frames; only looked at in IDLE
//   fifo_empty    FIFO empty flag
//   fifo_rd_data  FIFO read data, valid the cycle after the fifo_rd_en pulse
//   fifo_rd_en    FIFO pop request, registered single-cycle pulse
//   tx            serial line, idles high, registered
//   busy          high in every state except IDLE
//   tx_done       one-cycle pulse following the edge that ends the stop period
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rd_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    STOP   = 3'd6
  } state_t;
`endif

  state_t              state, state_nxt;
  logic [BAUD_W-1:0]   baud_cnt, baud_nxt;
  logic [2:0]          bit_cnt, bit_nxt;
  logic [7:0]          shreg, shreg_nxt;
  logic                tx_nxt;
  logic                rd_en_nxt;
  logic                done_nxt;
  logic                bit_tick;

`ifdef FIFO_UART_TX_PARITY_EN
  logic                parity_bit, parity_nxt;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  // A bit period ends when the baud counter reaches its last count.
  assign bit_tick = (baud_cnt == BAUD_LAST);
  assign busy     = (state != IDLE);

  // State and registered outputs; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      tx_done    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= shreg_nxt;
      tx         <= tx_nxt;
      fifo_rd_en <= rd_en_nxt;
      tx_done    <= done_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= parity_nxt;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    baud_nxt  = bit_tick ? '0 : baud_cnt + BAUD_W'(1);
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    tx_nxt    = tx;
    rd_en_nxt = 1'b0;
    done_nxt  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_nxt = parity_bit;
`endif

    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        baud_nxt = '0;
        bit_nxt  = '0;
        if (enable && !fifo_empty) begin
          state_nxt = FETCH;
          rd_en_nxt = 1'b1;
        end
      end

      // The FIFO registers its read during this cycle; data appears in LOAD.
      FETCH: begin
        baud_nxt  = '0;
        state_nxt = LOAD;
      end

      LOAD: begin
        baud_nxt  = '0;
        bit_nxt   = '0;
        shreg_nxt = fifo_rd_data;
        tx_nxt    = 1'b0;
        state_nxt = START;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_nxt = even_parity(fifo_rd_data);
`endif
      end

      START: begin
        if (bit_tick) begin
          state_nxt = DATA;
          bit_nxt   = '0;
          tx_nxt    = shreg[0];
        end
      end

      // shreg[0] is the bit currently on the line, so the next bit is shreg[1].
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt == 3'd7) begin
            bit_nxt = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_nxt = PARITY;
            tx_nxt    = parity_bit;
`else
            state_nxt = STOP;
            tx_nxt    = 1'b1;
`endif
          end else begin
            bit_nxt   = bit_cnt + 3'd1;
            shreg_nxt = {1'b0, shreg[7:1]};
            tx_nxt    = shreg[1];
          end
        end
      end

`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_nxt = STOP;
          bit_nxt   = '0;
          tx_nxt    = 1'b1;
        end
      end
`endif

      // bit_cnt counts stop bits here so two stop bits reuse the baud counter.
      STOP: begin
        tx_nxt = 1'b1;
        if (bit_tick) begin
          if (bit_cnt == STOP_LAST) begin
            state_nxt = IDLE;
            bit_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
        bit_nxt   = '0;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (10 + P) * C;
  localparam int SZ    = 8192;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int underflow = 0;

  logic wave  [SZ];
  logic rdh   [SZ];
  logic doneh [SZ];
  logic busyh [SZ];

  // FIFO model with registered read port
  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  fifo_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .tx           (tx),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en === 1'b1) begin
      if (wr_ptr != rd_ptr) begin
        fifo_rd_data <= mem[rd_ptr % 16];
        rd_ptr <= rd_ptr + 1;
      end else begin
        underflow <= underflow + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc < SZ) begin
      wave[cyc]  = tx;
      rdh[cyc]   = fifo_rd_en;
      doneh[cyc] = tx_done;
      busyh[cyc] = busy;
    end
  end

  task automatic wait_cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 16] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  function automatic int find_fall(input int from, input int to);
    for (int i = from; i <= to; i++)
      if (i > 0 && i < SZ && wave[i-1] === 1'b1 && wave[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int find_rd(input int from, input int to);
    for (int i = from; i <= to; i++)
      if (i > 0 && i < SZ && rdh[i] === 1'b1 && rdh[i-1] !== 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_rd_high(input int from, input int to);
    int n = 0;
    for (int i = from; i <= to; i++)
      if (i >= 0 && i < SZ && rdh[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_done(input int from, input int to);
    int n = 0;
    for (int i = from; i <= to; i++)
      if (i >= 0 && i < SZ && doneh[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (tx !== 1'b1)         begin n_fail++; $display("FAIL reset_tx got=%b want=1", tx); end
    n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b want=0", fifo_rd_en); end
    n_cmp++; if (tx_done !== 1'b0)    begin n_fail++; $display("FAIL reset_tx_done got=%b want=0", tx_done); end
    for (int i = 0; i < 3; i++) begin
      wait_cyc();
      n_cmp++;
      if ({tx, busy, fifo_rd_en, tx_done} !== 4'b1000)
        begin n_fail++; $display("FAIL reset_hold cyc=%0d got=%b want=1000", i, {tx, busy, fifo_rd_en, tx_done}); end
    end
    reset = 1'b0;
    wait_cyc(2);
    n_cmp++; if ({tx, busy} !== 2'b10) begin n_fail++; $display("FAIL reset_release got=%b want=10", {tx, busy}); end
  endtask

  task automatic test_empty();
    enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      wait_cyc();
      n_cmp++;
      if ({fifo_rd_en, tx, busy} !== 3'b010)
        begin n_fail++; $display("FAIL empty_idle cyc=%0d got=%b want=010", i, {fifo_rd_en, tx, busy}); end
    end
  endtask

  task automatic test_single();
    int base, rd, fall, done_i;
    bit got;
    base = cyc;
    push(8'hA5);
    got = 0;
    for (int i = 0; i < 120 && !got; i++) begin
      wait_cyc();
      if (doneh[cyc] === 1'b1) got = 1;
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL single_done_timeout got=none want=pulse"); end
    done_i = cyc;
    wait_cyc(3);
    rd   = find_rd(base + 1, cyc);
    fall = find_fall(base + 1, cyc);
    n_cmp++; if (count_rd_high(base + 1, cyc) !== 1)
      begin n_fail++; $display("FAIL single_rd_width got=%0d want=1", count_rd_high(base + 1, cyc)); end
    n_cmp++; if (fall - rd !== 2)
      begin n_fail++; $display("FAIL single_fall_latency got=%0d want=2", fall - rd); end
    for (int k = 0; k < FRAME; k++) begin
      n_cmp++;
      if (wave[fall + k] !== frame_bit(8'hA5, k / C))
        begin n_fail++; $display("FAIL single_bits idx=%0d got=%b want=%b", k, wave[fall + k], frame_bit(8'hA5, k / C)); end
    end
    n_cmp++; if (done_i !== fall + FRAME)
      begin n_fail++; $display("FAIL single_done_time got=%0d want=%0d", done_i - fall, FRAME); end
    n_cmp++; if (count_done(base + 1, cyc) !== 1)
      begin n_fail++; $display("FAIL single_done_count got=%0d want=1", count_done(base + 1, cyc)); end
    n_cmp++; if (busyh[fall] !== 1'b1) begin n_fail++; $display("FAIL single_busy_frame got=%b want=1", busyh[fall]); end
    n_cmp++; if (busyh[done_i] !== 1'b0) begin n_fail++; $display("FAIL single_busy_done got=%b want=0", busyh[done_i]); end
  endtask

  task automatic test_back_to_back();
    int base, rd1, rd2, fall1, fall2;
    bit got;
    base = cyc;
    push(8'h55);
    push(8'h0F);
    got = 0;
    for (int i = 0; i < 250 && !got; i++) begin
      wait_cyc();
      if (count_done(base + 1, cyc) >= 2) got = 1;
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL b2b_done_timeout got=%0d want=2", count_done(base + 1, cyc)); end
    wait_cyc(2);
    rd1   = find_rd(base + 1, cyc);
    rd2   = find_rd(rd1 + 1, cyc);
    fall1 = find_fall(base + 1, cyc);
    fall2 = find_fall(fall1 + FRAME, cyc);
    n_cmp++; if (count_rd_high(base + 1, cyc) !== 2)
      begin n_fail++; $display("FAIL b2b_rd_cycles got=%0d want=2", count_rd_high(base + 1, cyc)); end
    n_cmp++; if (rd2 !== fall1 + FRAME + 1)
      begin n_fail++; $display("FAIL b2b_rd2_time got=%0d want=%0d", rd2 - fall1, FRAME + 1); end
    n_cmp++; if (fall2 !== fall1 + FRAME + 3)
      begin n_fail++; $display("FAIL b2b_gap got=%0d want=%0d", fall2 - fall1, FRAME + 3); end
    for (int k = 0; k < FRAME; k++) begin
      n_cmp++;
      if (wave[fall1 + k] !== frame_bit(8'h55, k / C))
        begin n_fail++; $display("FAIL b2b_bits1 idx=%0d got=%b want=%b", k, wave[fall1 + k], frame_bit(8'h55, k / C)); end
      n_cmp++;
      if (wave[fall2 + k] !== frame_bit(8'h0F, k / C))
        begin n_fail++; $display("FAIL b2b_bits2 idx=%0d got=%b want=%b", k, wave[fall2 + k], frame_bit(8'h0F, k / C)); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int fall, rel, rd, fall2;
    bit got;
    push(8'hFF);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      wait_cyc();
      if (wave[cyc] === 1'b0) got = 1;
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL rstmid_start_timeout got=none want=start"); end
    fall = cyc;
    // land in the second cycle of data bit 3
    wait_cyc(C + 3 * C + 1);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before got=%b want=1", busy); end
    reset = 1'b1;
    #1;
    n_cmp++; if (tx !== 1'b1)         begin n_fail++; $display("FAIL rstmid_tx got=%b want=1", tx); end
    n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_en got=%b want=0", fifo_rd_en); end
    push(8'h96);
    wait_cyc(2);
    reset = 1'b0;
    rel = cyc;
    got = 0;
    for (int i = 0; i < 120 && !got; i++) begin
      wait_cyc();
      if (doneh[cyc] === 1'b1) got = 1;
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL rstmid_done_timeout got=none want=pulse"); end
    rd    = find_rd(rel, cyc);
    fall2 = find_fall(rel, cyc);
    n_cmp++; if (rd !== rel + 1) begin n_fail++; $display("FAIL rstmid_refetch got=%0d want=1", rd - rel); end
    n_cmp++; if (fall2 !== rd + 2) begin n_fail++; $display("FAIL rstmid_fall got=%0d want=2", fall2 - rd); end
    for (int i = rel; i < rd + 2; i++) begin
      n_cmp++;
      if (wave[i] !== 1'b1) begin n_fail++; $display("FAIL rstmid_glitch idx=%0d got=%b want=1", i - rel, wave[i]); end
    end
    for (int k = 0; k < FRAME; k++) begin
      n_cmp++;
      if (wave[fall2 + k] !== frame_bit(8'h96, k / C))
        begin n_fail++; $display("FAIL rstmid_bits idx=%0d got=%b want=%b", k, wave[fall2 + k], frame_bit(8'h96, k / C)); end
    end
  endtask

  task automatic test_enable_drop();
    int base, fall, done_i, en_cyc, rd, fall2;
    bit got;
    wait_cyc(3);
    base = cyc;
    push(8'h3C);
    push(8'h11);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      wait_cyc();
      if (wave[cyc] === 1'b0) got = 1;
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL endrop_start_timeout got=none want=start"); end
    fall = cyc;
    wait_cyc(2 * C);
    enable = 1'b0;
    got = 0;
    for (int i = 0; i < 120 && !got; i++) begin
      wait_cyc();
      if (doneh[cyc] === 1'b1) got = 1;
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL endrop_done_timeout got=none want=pulse"); end
    done_i = cyc;
    n_cmp++; if (done_i !== fall + FRAME)
      begin n_fail++; $display("FAIL endrop_done_time got=%0d want=%0d", done_i - fall, FRAME); end
    for (int k = 0; k < FRAME; k++) begin
      n_cmp++;
      if (wave[fall + k] !== frame_bit(8'h3C, k / C))
        begin n_fail++; $display("FAIL endrop_bits idx=%0d got=%b want=%b", k, wave[fall + k], frame_bit(8'h3C, k / C)); end
    end
    wait_cyc(20);
    n_cmp++; if (count_rd_high(base + 1, cyc) !== 1)
      begin n_fail++; $display("FAIL endrop_no_fetch got=%0d want=1", count_rd_high(base + 1, cyc)); end
    n_cmp++; if ({busy, tx} !== 2'b01) begin n_fail++; $display("FAIL endrop_idle got=%b want=01", {busy, tx}); end
    en_cyc = cyc;
    enable = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      wait_cyc();
      if (rdh[cyc] === 1'b1) got = 1;
    end
    rd = cyc;
    n_cmp++; if (!got || rd - en_cyc > 3)
      begin n_fail++; $display("FAIL endrop_restart got=%0d want<=3", rd - en_cyc); end
    got = 0;
    for (int i = 0; i < 120 && !got; i++) begin
      wait_cyc();
      if (doneh[cyc] === 1'b1) got = 1;
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL endrop_done2_timeout got=none want=pulse"); end
    fall2 = find_fall(rd, cyc);
    n_cmp++; if (fall2 !== rd + 2) begin n_fail++; $display("FAIL endrop_fall2 got=%0d want=2", fall2 - rd); end
    for (int k = 0; k < FRAME; k++) begin
      n_cmp++;
      if (wave[fall2 + k] !== frame_bit(8'h11, k / C))
        begin n_fail++; $display("FAIL endrop_bits2 idx=%0d got=%b want=%b", k, wave[fall2 + k], frame_bit(8'h11, k / C)); end
    end
  endtask

  task automatic test_no_underflow();
    wait_cyc(10);
    n_cmp++; if (underflow !== 0) begin n_fail++; $display("FAIL underflow got=%0d want=0", underflow); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL fifo_drained got=%b want=1", fifo_empty); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
    test_enable_drop();
    test_no_underflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard stop in case a task loop misbehaves
  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
